crc16_gen64: RTL and testbench
==============================

# crc16_gen64

Transmit-side CRC block for the bus-comparator datapath. Accepts a 48-bit payload, computes a CRC-16 over its six bytes (MSB byte first), and produces a 64-bit frame {payload, crc}. The frame is presented in parallel and also streamed byte-serially, so the downstream 64-bit CRC checker can consume it directly. Registers update on the falling edge of `clk`, matching the checker.

## Interface
- No parameters.
- The CRC is CRC-16/CCITT-FALSE and is fixed in RTL:
  - polynomial 0x1021, init 0xFFFF;
  - no input/output reflection, no final XOR.
- `clk` in 1: single clock; all registers update on negedge `clk`.
- `rst1` in 1: reset is synchronous and active-high.
- `start` in 1: request to encode. Honoured only in IDLE; ignored in every other state.
- `dataIn` in 48: payload, sampled on the edge where `start` is accepted.
- `busy` out 1: high from the accept edge until the edge after the last streamed byte.
- `frameOut` out 64: {payload, crc}. Holds its value until the next frame completes.
- `frameValid` out 1: one-cycle pulse when `frameOut` updates.
- `byteOut` out 8: serial frame byte, frame[63:56] first.
- `byteValid` out 1: high for the 8 consecutive cycles on which `byteOut` is valid.

## Operation
- Reset (`rst1`=1 at an edge) outputs:
  - `busy`=0, `frameValid`=0, `byteValid`=0;
  - `byteOut`=8'h00, `frameOut`=64'h0;
  - internal crc=16'hFFFF, state=IDLE.
- Reset overrides every state; a frame in progress is discarded with no partial `frameValid`.
- States: IDLE, CALC, APPEND, STREAM.
- IDLE:
  - On `start`=1: latch `dataIn` into payload register; crc<=0xFFFF; byte index<=0; `busy`<=1; go to CALC.
- CALC: one byte per cycle, index 0..5, byte = payload[47-8i -: 8].
  - Per byte: crc <= crc16_byte(crc, byte), i.e. 8 shift steps, MSB first.
  - Each step: fb = crc[15] ^ d[7-k]; crc = {crc[14:0],1'b0} ^ (fb ? 16'h1021 : 0).
  - After index 5, go to APPEND.
- APPEND:
  - frameOut <= {payload, crc}; `frameValid`<=1 for this one cycle.
  - stream index<=0; go to STREAM.
- STREAM:
  - byteOut <= frameOut[63-8j -: 8]; byteValid<=1; j=0..7.
  - After j=7: byteValid<=0, busy<=0, go to IDLE.
- `start` while busy is dropped, not queued. `dataIn` changes after acceptance have no effect.
- Default/illegal state → IDLE with outputs at their reset values.
- Round-trip property: running the same CRC over all 8 frame bytes with init 0xFFFF yields residue 0x0000.

## Timing
- Edge E0: `start` accepted, `busy` rises.
- Edges E1..E6: the six CRC byte updates.
- Edge E7: `frameOut` valid, `frameValid` high for cycle E7..E8.
- Edges E8..E15: `byteValid` high with bytes 0..7.
- Edge E16: `byteValid` and `busy` fall.
- A new `start` is accepted at E16 at the earliest. Minimum frame-to-frame period is 16 clocks.
- `start` held high continuously gives back-to-back frames every 16 clocks, each sampling the `dataIn` present at its own accept edge.
- `start` and `rst1` asserted at the same edge: reset wins, state stays IDLE.

## Test plan
- Reset values: assert `rst1` 2 cycles, release → all outputs at reset values, `busy`=0, no pulses for 20 idle cycles.
- Known vector:
  - `dataIn`=48'h313233343536 ("123456"), compare against the software CRC-16/CCITT-FALSE model.
  - Check `frameValid` exactly at E7 and `frameOut`[63:16]=48'h313233343536.
  - Zero payload 48'h0 → crc from the model, frame bytes 00×6 then crc MSB, LSB.
- Round trip: 200 random payloads → recompute CRC over the 8 streamed bytes gives 0x0000. `byteOut` order matches `frameOut` MSB-first, `byteValid` high exactly 8 cycles.
- Start while busy: pulse `start` at E3 and E10 with different `dataIn` → no effect, one frame only, `frameOut` reflects E0 payload.
- Back-to-back: hold `start`=1 with `dataIn` changing every cycle → accepts at E0, E16, E32. Each frame uses its accept-edge payload.
- Reset mid-operation: assert `rst1` at E4 (CALC) and again in another run at E11 (STREAM) → next edge returns all outputs to reset values. No `frameValid`. The next `start` produces a correct frame.

Source files
------------

// File: rtl/crc16_gen64.sv
// Transmit-side CRC-16/CCITT-FALSE framer: 48-bit payload in, {payload, crc} out
// in parallel and as an 8-byte MSB-first stream. All registers update on negedge clk.
module crc16_gen64 (
    input  logic        clk,
    input  logic        rst1,
    input  logic        start,
    input  logic [47:0] dataIn,
    output logic        busy,
    output logic [63:0] frameOut,
    output logic        frameValid,
    output logic [7:0]  byteOut,
    output logic        byteValid
);

    localparam int unsigned PAYLOAD_W = 48;
    localparam int unsigned CRC_W     = 16;
    localparam int unsigned FRAME_W   = PAYLOAD_W + CRC_W;
    localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;
    localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        APPEND = 2'd2,
        STREAM = 2'd3
    } state_t;

    state_t               state_q;
    logic [PAYLOAD_W-1:0] payload_q;
    logic [PAYLOAD_W-1:0] work_q;
    logic [CRC_W-1:0]     crc_q;
    logic [2:0]           idx_q;
    logic [FRAME_W-1:0]   shift_q;
    logic                 busy_q;
    logic [FRAME_W-1:0]   frame_q;
    logic                 frame_valid_q;
    logic [7:0]           byte_q;
    logic                 byte_valid_q;

    // One CRC byte update, eight MSB-first shift steps.
    function automatic logic [CRC_W-1:0] crc16_byte(input logic [CRC_W-1:0] c,
                                                    input logic [7:0] d);
        logic [CRC_W-1:0] r;
        logic             fb;
        r = c;
        for (int k = 7; k >= 0; k--) begin
            fb = r[CRC_W-1] ^ d[k];
            r  = {r[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
        return r;
    endfunction

    always_ff @(negedge clk) begin
        if (rst1) begin
            state_q       <= IDLE;
            payload_q     <= '0;
            work_q        <= '0;
            crc_q         <= CRC_INIT;
            idx_q         <= '0;
            shift_q       <= '0;
            busy_q        <= 1'b0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            byte_q        <= '0;
            byte_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                // The edge after the last byte lands here, so a new start is taken on it.
                IDLE: begin
                    frame_valid_q <= 1'b0;
                    byte_valid_q  <= 1'b0;
                    busy_q        <= 1'b0;
                    if (start) begin
                        payload_q <= dataIn;
                        work_q    <= dataIn;
                        crc_q     <= CRC_INIT;
                        idx_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= CALC;
                    end
                end
                CALC: begin
                    crc_q  <= crc16_byte(crc_q, work_q[PAYLOAD_W-1 -: 8]);
                    work_q <= {work_q[PAYLOAD_W-9:0], 8'h00};
                    idx_q  <= idx_q + 3'd1;
                    if (idx_q == 3'd5) begin
                        state_q <= APPEND;
                    end
                end
                APPEND: begin
                    frame_q       <= {payload_q, crc_q};
                    shift_q       <= {payload_q, crc_q};
                    frame_valid_q <= 1'b1;
                    idx_q         <= '0;
                    state_q       <= STREAM;
                end
                STREAM: begin
                    frame_valid_q <= 1'b0;
                    byte_q        <= shift_q[FRAME_W-1 -: 8];
                    shift_q       <= {shift_q[FRAME_W-9:0], 8'h00};
                    byte_valid_q  <= 1'b1;
                    idx_q         <= idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    crc_q         <= CRC_INIT;
                    idx_q         <= '0;
                    busy_q        <= 1'b0;
                    frame_q       <= '0;
                    frame_valid_q <= 1'b0;
                    byte_q        <= '0;
                    byte_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign frameOut   = frame_q;
    assign frameValid = frame_valid_q;
    assign byteOut    = byte_q;
    assign byteValid  = byte_valid_q;

endmodule

// File: tb/tb_crc16_gen64.sv
// Self-checking bench for crc16_gen64; reference CRC is polynomial long division.
module tb_crc16_gen64;

    logic        clk = 1'b0;
    logic        rst1;
    logic        start;
    logic [47:0] dataIn;
    logic        busy;
    logic [63:0] frameOut;
    logic        frameValid;
    logic [7:0]  byteOut;
    logic        byteValid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    crc16_gen64 dut (
        .clk        (clk),
        .rst1       (rst1),
        .start      (start),
        .dataIn     (dataIn),
        .busy       (busy),
        .frameOut   (frameOut),
        .frameValid (frameValid),
        .byteOut    (byteOut),
        .byteValid  (byteValid)
    );

    // CRC with init I over n-bit message M is (M*x^16 + I*x^n) mod P.
    function automatic logic [15:0] poly_mod(input logic [63:0] msg, input int nbits);
        logic [79:0] v;
        logic [79:0] p;
        logic [79:0] init;
        p    = 80'h11021;
        init = 80'hFFFF;
        v    = {msg, 16'h0000} ^ (init << nbits);
        for (int i = nbits + 15; i >= 16; i--) begin
            if (v[i]) v = v ^ (p << (i - 16));
        end
        return v[15:0];
    endfunction

    function automatic logic [47:0] rand48();
        return {16'($urandom()), 32'($urandom())};
    endfunction

    function automatic logic [63:0] model_frame(input logic [47:0] pl);
        return {pl, poly_mod({16'h0000, pl}, 48)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},   64'(busy), 64'd0);
        chk({tag, "_fvalid"}, 64'(frameValid), 64'd0);
        chk({tag, "_bvalid"}, 64'(byteValid), 64'd0);
        chk({tag, "_byte"},   64'(byteOut), 64'd0);
        chk({tag, "_frame"},  frameOut, 64'd0);
    endtask

    // One frame from an idle DUT; optional start pulses while busy and reset at edge rst_at.
    task automatic run_frame(input logic [47:0] pl, input bit pulse, input int rst_at);
        logic [63:0] exp_f;
        logic [63:0] got;
        exp_f = model_frame(pl);
        got   = '0;
        start  = 1'b1;
        dataIn = pl;
        step();
        chk("accept_busy", 64'(busy), 64'd1);
        for (int e = 1; e <= 16; e++) begin
            start  = pulse && (e == 3 || e == 10);
            dataIn = rand48();
            rst1   = (e == rst_at);
            step();
            if (e == rst_at) begin
                rst1  = 1'b0;
                start = 1'b0;
                chk_reset_outputs("midrst");
                for (int k = 0; k < 12; k++) begin
                    step();
                    chk("midrst_quiet", {62'd0, frameValid, busy}, 64'd0);
                end
                return;
            end
            if (e <= 6) begin
                chk("calc_fvalid", 64'(frameValid), 64'd0);
                chk("calc_busy", 64'(busy), 64'd1);
            end else if (e == 7) begin
                chk("e7_fvalid", 64'(frameValid), 64'd1);
                chk("e7_frame", frameOut, exp_f);
                chk("e7_bvalid", 64'(byteValid), 64'd0);
            end else if (e <= 15) begin
                if (e == 8) chk("e8_fvalid", 64'(frameValid), 64'd0);
                chk("stream_bvalid", 64'(byteValid), 64'd1);
                chk("stream_byte", 64'(byteOut), 64'(exp_f[63 - 8*(e-8) -: 8]));
                got = {got[55:0], byteOut};
            end else begin
                chk("e16_bvalid", 64'(byteValid), 64'd0);
                chk("e16_busy", 64'(busy), 64'd0);
                chk("stream_frame", got, exp_f);
                chk("residue", 64'(poly_mod(got, 64)), 64'd0);
                chk("frame_hold", frameOut, exp_f);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        logic [47:0] cur;
        logic [47:0] p;
        logic [63:0] exp_f;
        int          ph;

        rst1   = 1'b1;
        start  = 1'b0;
        dataIn = '0;
        step();
        step();
        chk_reset_outputs("reset");
        rst1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_quiet", {61'd0, busy, frameValid, byteValid}, 64'd0);
        end

        // Reset and start on the same edge: reset wins.
        rst1   = 1'b1;
        start  = 1'b1;
        dataIn = rand48();
        step();
        rst1  = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", 64'(busy), 64'd0);
        step();
        chk("rst_start_after", {62'd0, busy, frameValid}, 64'd0);

        run_frame(48'h313233343536, 1'b0, 0);
        chk("ascii_payload", 64'(frameOut[63:16]), 64'h313233343536);
        run_frame(48'h0, 1'b0, 0);
        chk("zero_payload", frameOut, {48'h0, poly_mod(64'd0, 48)});

        run_frame(rand48(), 1'b1, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("no_second_frame", {62'd0, busy, frameValid}, 64'd0);
        end

        // Start held high: accepts every 16 edges with the payload present at each accept.
        p     = '0;
        exp_f = '0;
        for (int k = 0; k < 48; k++) begin
            cur    = rand48();
            start  = 1'b1;
            dataIn = cur;
            ph     = k % 16;
            if (ph == 0) begin
                p     = cur;
                exp_f = model_frame(cur);
            end
            step();
            if (ph == 0) begin
                chk("b2b_busy", 64'(busy), 64'd1);
                chk("b2b_bvalid", 64'(byteValid), 64'd0);
            end else if (ph <= 6) begin
                chk("b2b_fvalid_lo", 64'(frameValid), 64'd0);
            end else if (ph == 7) begin
                chk("b2b_fvalid", 64'(frameValid), 64'd1);
                chk("b2b_frame", frameOut, exp_f);
            end else begin
                chk("b2b_byte", 64'(byteOut), 64'(exp_f[63 - 8*(ph-8) -: 8]));
            end
        end
        start = 1'b0;
        step();
        chk("b2b_end", {62'd0, busy, byteValid}, 64'd0);
        chk("b2b_last_payload", 64'(frameOut[63:16]), 64'(p));

        run_frame(rand48(), 1'b0, 4);
        run_frame(rand48(), 1'b0, 0);
        run_frame(rand48(), 1'b0, 11);
        run_frame(rand48(), 1'b0, 0);

        for (int i = 0; i < 200; i++) begin
            run_frame(rand48(), 1'b0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
